// File: rtl/bypass_crossfade.sv
// rtl/bypass_crossfade.sv - click-free dry/wet crossfade driven by a linear gain ramp
module bypass_crossfade #(
    parameter int DW     = 24,
    parameter int RAMP_W = 10
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          sample_tick_i,
    input  logic          enable_i,
    input  logic [DW-1:0] dry_i,
    input  logic [DW-1:0] wet_i,
    output logic [DW-1:0] data_o,
    output logic          data_valid_o,
    output logic          busy_o
);

    localparam int PW = DW + RAMP_W + 2;
    localparam int GW = RAMP_W + 1;
    localparam logic [GW-1:0] GMAX = {1'b1, {RAMP_W{1'b0}}};

    typedef enum logic [1:0] {
        S_DRY      = 2'd0,
        S_FADE_IN  = 2'd1,
        S_WET      = 2'd2,
        S_FADE_OUT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        g_q, g_d;
    logic                 busy_q, busy_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic [DW-1:0]        dry_q, dry_d;
    logic                 v1_q, v1_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 valid_q, valid_d;

    logic [GW-1:0]        g_inc, g_dec;
    logic signed [DW:0]   diff;

    // Gain ramp FSM; advances only on sample ticks, and a direction change
    // reverses from the current gain so the output never jumps.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        g_inc   = g_q + 1'b1;
        g_dec   = g_q - 1'b1;
        if (sample_tick_i) begin
            case (state_q)
                S_DRY: begin
                    if (enable_i) begin
                        state_d = S_FADE_IN;
                        g_d     = {{(GW-1){1'b0}}, 1'b1};
                    end else begin
                        g_d = '0;
                    end
                end
                S_FADE_IN: begin
                    if (enable_i) begin
                        g_d = g_inc;
                        if (g_inc == GMAX) state_d = S_WET;
                    end else begin
                        g_d     = g_dec;
                        state_d = (g_dec == '0) ? S_DRY : S_FADE_OUT;
                    end
                end
                S_WET: begin
                    if (!enable_i) begin
                        state_d = S_FADE_OUT;
                        g_d     = GMAX - 1'b1;
                    end else begin
                        g_d = GMAX;
                    end
                end
                default: begin
                    if (!enable_i) begin
                        g_d = g_dec;
                        if (g_dec == '0) state_d = S_DRY;
                    end else begin
                        g_d     = g_inc;
                        state_d = (g_inc == GMAX) ? S_WET : S_FADE_IN;
                    end
                end
            endcase
        end
        busy_d = (state_d == S_FADE_IN) || (state_d == S_FADE_OUT);
    end

    // Two-stage mix: dry + (wet-dry)*g/GMAX, using the gain held before this tick.
    always_comb begin
        diff    = $signed({wet_i[DW-1], wet_i}) - $signed({dry_i[DW-1], dry_i});
        prod_d  = prod_q;
        dry_d   = dry_q;
        v1_d    = sample_tick_i;
        data_d  = data_q;
        valid_d = v1_q;
        if (sample_tick_i) begin
            prod_d = PW'(diff) * $signed(PW'(g_q));
            dry_d  = dry_i;
        end
        if (v1_q) begin
            data_d = dry_q + DW'(prod_q >>> RAMP_W);
        end
    end

    // State, gain and pipeline registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= S_DRY;
            g_q     <= '0;
            busy_q  <= 1'b0;
            prod_q  <= '0;
            dry_q   <= '0;
            v1_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            prod_q  <= prod_d;
            dry_q   <= dry_d;
            v1_q    <= v1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_bypass_crossfade.sv
// tb/tb_bypass_crossfade.sv - scoreboard bench for bypass_crossfade
module tb_bypass_crossfade;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        sample_tick_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [23:0] dry_i = '0;
    logic [23:0] wet_i = '0;
    logic [23:0] data_o;
    logic        data_valid_o;
    logic        busy_o;

    bypass_crossfade #(.DW(24), .RAMP_W(4)) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .sample_tick_i (sample_tick_i),
        .enable_i      (enable_i),
        .dry_i         (dry_i),
        .wet_i         (wet_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint data;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     m_state = 0;
    int     m_g = 0;
    logic   m_busy = 1'b0;
    longint m_last = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor16(input longint n);
        longint q;
        q = n / 16;
        if ((n % 16 != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_tick(input logic en);
        case (m_state)
            0: if (en) begin m_state = 1; m_g = 1; end
            1: if (en) begin
                   m_g++;
                   if (m_g == 16) m_state = 2;
               end else begin
                   m_g--;
                   m_state = (m_g == 0) ? 0 : 3;
               end
            2: if (!en) begin m_state = 3; m_g = 15; end
            default: if (!en) begin
                   m_g--;
                   if (m_g == 0) m_state = 0;
               end else begin
                   m_g++;
                   m_state = (m_g == 16) ? 2 : 1;
               end
        endcase
        m_busy = (m_state == 1) || (m_state == 3);
    endtask

    task automatic step(input logic tk, input logic en, input longint dry, input longint wet);
        exp_t e;
        sample_tick_i = tk;
        enable_i      = en;
        dry_i         = dry[23:0];
        wet_i         = wet[23:0];
        if (tk) begin
            e.data = dry + floor16((wet - dry) * m_g);
            e.cyc  = cyc + 2;
            m_last = e.data;
            exp_q.push_back(e);
            model_tick(en);
        end
        @(posedge clk_i);
        #1;
        sample_tick_i = 1'b0;
        chk("busy", longint'(busy_o), longint'(m_busy));
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        sample_tick_i = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_state = 0;
        m_g     = 0;
        m_busy  = 1'b0;
        m_last  = 0;
        @(posedge clk_i);
        #1;
        chk("rst_data", $signed(data_o), 0);
        chk("rst_valid", longint'(data_valid_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_g", longint'(dut.g_q), 0);
        srst_i = 1'b0;
    endtask

    // Scoreboard: every valid output must match the oldest expected sample
    // and appear exactly two clocks after its tick.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            exp_t m;
            m = exp_q.pop_front();
            chk("missing_valid", cyc, m.cyc);
        end
        if (data_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data", $signed(data_o), e.data);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // bypassed: output equals dry
        repeat (4) step(1, 0, 1000, 5000);
        // ramp in to wet and stay there
        repeat (20) step(1, 1, 1000, 5000);
        chk("wet_g", longint'(dut.g_q), 16);
        // ramp out back to dry
        repeat (18) step(1, 0, 1000, 5000);
        chk("dry_g", longint'(dut.g_q), 0);

        // reverse mid-ramp at g=8
        repeat (8) step(1, 1, 1000, 5000);
        chk("mid_g", longint'(dut.g_q), 8);
        repeat (8) step(1, 0, 1000, 5000);
        chk("rev_dry_g", longint'(dut.g_q), 0);
        repeat (2) step(1, 0, 1000, 5000);

        // signed extremes mixed at g=8
        repeat (8) step(1, 1, 1000, 5000);
        step(1, 0, -8388608, 8388607);
        chk("extreme_model", m_last, -1);
        repeat (8) step(1, 0, 1000, 5000);

        // sparse ticks: gain moves once per tick, output holds between
        for (int i = 0; i < 6; i++) begin
            step(1, 1, -2000, 3000);
            repeat (3) step(0, 1, 77, 99);
            chk("gated_g", longint'(dut.g_q), longint'(m_g));
            chk("hold_data", $signed(data_o), m_last);
        end

        // reset during FADE_IN, then restart
        do_reset();
        repeat (5) step(1, 1, 1000, 5000);
        chk("pre_rst_g", longint'(dut.g_q), 5);
        do_reset();
        step(1, 1, 1000, 5000);
        chk("restart_g", longint'(dut.g_q), 1);
        repeat (3) step(1, 1, 1000, 5000);

        repeat (4) step(0, 0, 0, 0);
        chk("drain", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
